// File: rtl/lfsr_packer.sv
// Serial-to-parallel packer for the LFSR bit generator: gates the generator's shift enable,
// packs bits LSB-first into wbits-bit words and emits them on valid/ready. Optional LFSR_PACK_CNT_EN adds word_cnt.
module lfsr_packer #(
  parameter int wbits = 8,
  parameter int cbits = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [cbits-1:0] req_words,
  input  logic             bit_in,
  output logic             bit_en,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [wbits-1:0] out_data,
  output logic             busy,
  output logic             done
`ifdef LFSR_PACK_CNT_EN
  ,
  output logic [cbits-1:0] word_cnt
`endif
);

  localparam int BW = $clog2(wbits);
  localparam logic [BW-1:0] LAST = BW'(wbits - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [wbits-1:0] shreg_q, shreg_d;
  logic [cbits-1:0] remaining_q, remaining_d;
  logic             out_val_q, out_val_d;
  logic [wbits-1:0] out_data_q, out_data_d;
  logic             done_q, done_d;
  logic             bit_en_q, busy_q;
  logic             accept_s, free_s, xfer_s;
  logic [wbits-1:0] xfer_word_s;

  // Next-state logic: a transfer moves a completed word into the output register
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    xfer_s      = 1'b0;
    xfer_word_s = shreg_q;
    accept_s    = out_val_q && out_rdy;
    free_s      = !out_val_q || out_rdy;

    if (accept_s) begin
      out_val_d = 1'b0;
    end else begin
      out_val_d = out_val_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (req_words != {cbits{1'b0}}) begin
            remaining_d = req_words;
            bitcnt_d    = {BW{1'b0}};
            state_d     = FILL;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        shreg_d[bitcnt_q] = bit_in;
        if (bitcnt_q == LAST) begin
          bitcnt_d = {BW{1'b0}};
          if (free_s) begin
            xfer_s      = 1'b1;
            xfer_word_s = shreg_d;
          end else begin
            state_d = STALL;
          end
        end else begin
          bitcnt_d = bitcnt_q + BW'(1);
        end
      end
      STALL: begin
        if (out_rdy) begin
          xfer_s      = 1'b1;
          xfer_word_s = shreg_q;
        end else begin
          state_d = STALL;
        end
      end
      DRAIN: begin
        if (accept_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Compare before decrementing so req_words = all-ones never wraps the test
    if (xfer_s) begin
      out_val_d   = 1'b1;
      out_data_d  = xfer_word_s;
      remaining_d = remaining_q - cbits'(1);
      state_d     = (remaining_q > cbits'(1)) ? FILL : DRAIN;
    end else begin
      out_data_d = out_data_d;
    end
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bitcnt_q    <= {BW{1'b0}};
      shreg_q     <= {wbits{1'b0}};
      remaining_q <= {cbits{1'b0}};
      out_val_q   <= 1'b0;
      out_data_q  <= {wbits{1'b0}};
      done_q      <= 1'b0;
      bit_en_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      remaining_q <= remaining_d;
      out_val_q   <= out_val_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      bit_en_q    <= (state_d == FILL);
      busy_q      <= (state_d != IDLE);
    end
  end

`ifdef LFSR_PACK_CNT_EN
  logic [cbits-1:0] word_cnt_q;

  // Free-running count of accepted words; start does not clear it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt_q <= {cbits{1'b0}};
    end else if (accept_s) begin
      word_cnt_q <= word_cnt_q + cbits'(1);
    end else begin
      word_cnt_q <= word_cnt_q;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

  assign bit_en   = bit_en_q;
  assign busy     = busy_q;
  assign out_val  = out_val_q;
  assign out_data = out_data_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lfsr_packer.sv
// Directed self-checking bench for lfsr_packer; the serial source replays a bit vector,
// advancing one bit per edge on which bit_en was high.
module tb_lfsr_packer;

  logic        clk, rst, start, bit_in, bit_en, out_val, out_rdy, busy, done;
  logic [15:0] req_words;
  logic [7:0]  out_data;
`ifdef LFSR_PACK_CNT_EN
  logic [15:0] word_cnt;
`endif

  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          cyc_n, en_cnt, en_first, en_last, ov_cnt, ov_first, done_cnt, done_at, src_idx;
  logic [63:0] src_vec;
  logic [63:0] lv;
  logic [7:0]  got[$];

  lfsr_packer #(.wbits(8), .cbits(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .req_words (req_words),
    .bit_in    (bit_in),
    .bit_en    (bit_en),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
`ifdef LFSR_PACK_CNT_EN
    ,
    .word_cnt  (word_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got.size()) return got[i];
    else return 8'hxx;
  endfunction

  // Galois right-shift LFSR, output taken from bit 0
  function automatic logic [63:0] lfsr_bits(input logic [7:0] seed);
    logic [7:0]  s;
    logic [63:0] v;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      v[i] = s[0];
      s = {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
    end
    return v;
  endfunction

  task automatic load_src(input logic [63:0] v);
    src_vec = v;
    src_idx = 0;
    bit_in = v[0];
    got.delete();
    cyc_n = 0; en_cnt = 0; en_first = 0; en_last = 0;
    ov_cnt = 0; ov_first = 0; done_cnt = 0; done_at = 0;
  endtask

  // One clock: called and returns at a falling edge
  task automatic cyc();
    logic       acc, en;
    logic [7:0] d;
    acc = out_val && out_rdy;
    d   = out_data;
    en  = bit_en;
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    if (acc) got.push_back(d);
    if (en) begin
      src_idx++;
      en_cnt++;
      if (en_first == 0) en_first = cyc_n;
      en_last = cyc_n;
    end
    bit_in = (src_idx < 64) ? src_vec[src_idx] : 1'b0;
    if (out_val) begin
      ov_cnt++;
      if (ov_first == 0) ov_first = cyc_n;
    end
    if (done) begin
      done_cnt++;
      done_at = cyc_n;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_rdy = 1'b0; req_words = 16'd0; bit_in = 1'b0;
    #3 rst = 1'b0;
    #1;
    check_eq("rst_bit_en", 32'(bit_en), 32'd0);
    check_eq("rst_out_val", 32'(out_val), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single word 1,0,1,1,0,0,0,0
    load_src(64'h0D);
    out_rdy = 1'b1; req_words = 16'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    check_eq("t1_en_after_start", 32'(bit_en), 32'd1);
    wait_done(40);
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_busy_at_done", 32'(busy), 32'd0);
    check_eq("t1_words", 32'(got.size()), 32'd1);
    check_eq("t1_data", 32'(got_at(0)), 32'h0D);
    check_eq("t1_en_cycles", 32'(en_cnt), 32'd8);
    check_eq("t1_val_first", 32'(ov_first), 32'd9);
    check_eq("t1_val_cycles", 32'(ov_cnt), 32'd1);
    check_eq("t1_done_at", 32'(done_at), 32'd10);
    cyc();
    check_eq("t1_done_pulse", 32'(done), 32'd0);

    // Back-to-back, all ones
    load_src(64'hFFFF_FFFF_FFFF_FFFF);
    req_words = 16'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(60);
    check_eq("t2_words", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++) check_eq("t2_data", 32'(got_at(i)), 32'hFF);
    check_eq("t2_en_cycles", 32'(en_cnt), 32'd24);
    check_eq("t2_en_span", 32'(en_last - en_first + 1), 32'd24);
    cyc(); cyc();
    check_eq("t2_done_count", 32'(done_cnt), 32'd1);

    // Backpressure until cycle 40
    load_src(64'h3C_A5_96);
    out_rdy = 1'b0; req_words = 16'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    while (cyc_n < 40) cyc();
    check_eq("t3_stall_en", 32'(bit_en), 32'd0);
    check_eq("t3_stall_busy", 32'(busy), 32'd1);
    check_eq("t3_held_val", 32'(out_val), 32'd1);
    check_eq("t3_held_data", 32'(out_data), 32'h96);
    check_eq("t3_stall_bits", 32'(en_cnt), 32'd16);
    out_rdy = 1'b1;
    wait_done(40);
    check_eq("t3_words", 32'(got.size()), 32'd3);
    check_eq("t3_w0", 32'(got_at(0)), 32'h96);
    check_eq("t3_w1", 32'(got_at(1)), 32'hA5);
    check_eq("t3_w2", 32'(got_at(2)), 32'h3C);
    check_eq("t3_en_cycles", 32'(en_cnt), 32'd24);
    check_eq("t3_done_count", 32'(done_cnt), 32'd1);

    // Zero-length run
    load_src(64'h0);
    req_words = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    check_eq("t4_zero_done", 32'(done), 32'd1);
    check_eq("t4_zero_busy", 32'(busy), 32'd0);
    cyc();
    check_eq("t4_zero_done_pulse", 32'(done), 32'd0);
    check_eq("t4_zero_en", 32'(en_cnt), 32'd0);

    // start while busy is ignored
    load_src(64'hC3_81);
    req_words = 16'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    req_words = 16'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(60);
    for (int i = 0; i < 20; i++) cyc();
    check_eq("t4_busy_words", 32'(got.size()), 32'd2);
    check_eq("t4_busy_w0", 32'(got_at(0)), 32'h81);
    check_eq("t4_busy_w1", 32'(got_at(1)), 32'hC3);
    check_eq("t4_busy_en", 32'(en_cnt), 32'd16);
    check_eq("t4_busy_done", 32'(done_cnt), 32'd1);

    // Reset during bit 5 of word 2
    load_src(64'h77_E1_4B);
    req_words = 16'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (en_cnt < 13 && n < 60) begin
        cyc();
        n++;
      end
    end
    check_eq("t5_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("t5_async_en", 32'(bit_en), 32'd0);
    check_eq("t5_async_val", 32'(out_val), 32'd0);
    check_eq("t5_async_busy", 32'(busy), 32'd0);
    check_eq("t5_async_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(); cyc(); cyc();
    check_eq("t5_no_done", 32'(done_cnt), 32'd0);
    load_src(64'h5A);
    req_words = 16'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(40);
    check_eq("t5_words", 32'(got.size()), 32'd1);
    check_eq("t5_data", 32'(got_at(0)), 32'h5A);

    // Real LFSR stream, seed 01, taps B8
    lv = lfsr_bits(8'h01);
    load_src(lv);
    req_words = 16'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(60);
    check_eq("t6_words", 32'(got.size()), 32'd3);
    check_eq("t6_w0_hand", 32'(got_at(0)), 32'h71);
    check_eq("t6_w1", 32'(got_at(1)), 32'(lv[15:8]));
    check_eq("t6_w2", 32'(got_at(2)), 32'(lv[23:16]));
`ifdef LFSR_PACK_CNT_EN
    check_eq("t6_word_cnt", 32'(word_cnt), 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
